// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between the CPU control path and the
// debug/program-loader port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request (held until accepted)
//   cpu_gnt, cpu_rvalid, cpu_rdata  CPU grant, read valid, read data
//   cpu_hold                        freezes the CPU sequencer while it waits for a grant
//   dbg_req/we/addr/wdata           debug request, same semantics as the CPU side
//   dbg_lock                        debug keeps ownership regardless of the burst limit
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug grant, read valid, read data
//   mem_addr, mem_data, mem_we      memory pins (mem_q has 1-cycle registered read latency)
//   busy                            arbiter is not idle
//
// Optional feature: define ARB_ROUND_ROBIN_EN to hand an IDLE tie to the requester not
// served last. Without it the tie always goes to debug.

module mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StOwnCpu, StOwnDbg} state_e;

  localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);

  state_e            state_q, state_d;
  logic [7:0]        burst_q, burst_d;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_acc, dbg_acc;
  logic              other_pending;
  logic              burst_hit;
  logic              tie_to_dbg;

  assign cpu_acc   = cpu_req & (state_q == StOwnCpu);
  assign dbg_acc   = dbg_req & (state_q == StOwnDbg);
  assign burst_hit = (burst_q == BurstLast);

  assign other_pending = ((state_q == StOwnCpu) & dbg_req) | ((state_q == StOwnDbg) & cpu_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dbg_q;  // 1 = debug was served last; reset says CPU

  assign tie_to_dbg = ~last_dbg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b0;
    end else if (dbg_acc) begin
      last_dbg_q <= 1'b1;
    end else if (cpu_acc) begin
      last_dbg_q <= 1'b0;
    end
  end
`else
  assign tie_to_dbg = 1'b1;
`endif

  // Next ownership
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_req && cpu_req) begin
          state_d = tie_to_dbg ? StOwnDbg : StOwnCpu;
        end else if (dbg_req) begin
          state_d = StOwnDbg;
        end else if (cpu_req) begin
          state_d = StOwnCpu;
        end
      end
      StOwnCpu: begin
        if (!cpu_req) begin
          state_d = dbg_req ? StOwnDbg : StIdle;
        end else if (dbg_req && burst_hit) begin
          state_d = StOwnDbg;
        end
      end
      StOwnDbg: begin
        if (!dbg_req) begin
          state_d = cpu_req ? StOwnCpu : StIdle;
        end else if (cpu_req && burst_hit && !dbg_lock) begin
          state_d = StOwnCpu;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Burst counter only runs while the other side is waiting and ownership is stable
  always_comb begin
    burst_d = burst_q;
    if ((state_d != state_q) || !other_pending) begin
      burst_d = 8'd0;
    end else if ((cpu_acc || dbg_acc) && (burst_q != 8'hFF)) begin
      burst_d = burst_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      burst_q      <= 8'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      cpu_rvalid_q <= cpu_acc & ~cpu_we;
      dbg_rvalid_q <= dbg_acc & ~dbg_we;
      if (cpu_rvalid_q) cpu_rdata_q <= mem_q;
      if (dbg_rvalid_q) dbg_rdata_q <= mem_q;
      if (cpu_acc || dbg_acc) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_data;
      end
    end
  end

  // Memory pins follow the owner during an accept and otherwise hold the last access
  always_comb begin
    mem_addr = addr_q;
    mem_data = wdata_q;
    mem_we   = 1'b0;
    if (cpu_acc) begin
      mem_addr = cpu_addr;
      mem_data = cpu_wdata;
      mem_we   = cpu_we;
    end else if (dbg_acc) begin
      mem_addr = dbg_addr;
      mem_data = dbg_wdata;
      mem_we   = dbg_we;
    end
  end

  assign cpu_gnt    = (state_q == StOwnCpu);
  assign dbg_gnt    = (state_q == StOwnDbg);
  assign cpu_hold   = cpu_req & ~cpu_gnt;
  assign busy       = (state_q != StIdle);
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  // mem_q is already registered inside the memory, so pass it straight through on rvalid
  assign cpu_rdata  = cpu_rvalid_q ? mem_q : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid_q ? mem_q : dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_hold;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [15:0] mem_addr, mem_data, mem_q;
  logic        mem_we, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:65535];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_MAX(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_hold   (cpu_hold),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_q      (mem_q),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write and registered read on the same edge (read-old within a cycle)
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[16'h0010] <= 16'h1234;
      mem[16'h0020] <= 16'h5555;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
    mem_q <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0;
    cpu_wdata = 16'h0;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_lock  = 1'b0;
    dbg_addr  = 16'h0;
    dbg_wdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [15:0] data);
    bit got = 0;
    data     = 16'h0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = addr;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_gnt) begin
        got = 1;
        break;
      end
      step();
    end
    check_eq("cpu_read_gnt", 32'(got), 32'd1);
    step();
    cpu_req = 1'b0;
    if (got) begin
      @(negedge clk);
      check_eq("cpu_read_rvalid", 32'(cpu_rvalid), 32'd1);
      data = cpu_rdata;
      step();
    end
  endtask

  logic [15:0] rd;
  logic [1:0]  exp_own;

  initial begin
    // 1: reset state, then a lone CPU read
    do_reset();
    @(negedge clk);
    check_eq("rst_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
    check_eq("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check_eq("rst_busy_we", 32'({busy, mem_we}), 32'd0);
    step();
    cpu_req  = 1'b1;
    cpu_addr = 16'h0010;
    @(negedge clk);
    check_eq("t1_hold_c0", 32'(cpu_hold), 32'd1);
    check_eq("t1_gnt_c0", 32'(cpu_gnt), 32'd0);
    step();
    @(negedge clk);
    check_eq("t1_gnt_c1", 32'(cpu_gnt), 32'd1);
    check_eq("t1_hold_c1", 32'(cpu_hold), 32'd0);
    check_eq("t1_mem_addr", 32'(mem_addr), 32'h0010);
    check_eq("t1_mem_we", 32'(mem_we), 32'd0);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("t1_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("t1_rdata", 32'(cpu_rdata), 32'h1234);
    check_eq("t1_hold_c2", 32'(cpu_hold), 32'd0);
    step();
    @(negedge clk);
    check_eq("t1_rvalid_off", 32'(cpu_rvalid), 32'd0);
    check_eq("t1_rdata_held", 32'(cpu_rdata), 32'h1234);
    check_eq("t1_busy_idle", 32'(busy), 32'd0);
    step();

    // 2: debug write burst 0x0000..0x0004, then CPU reads one back
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 16'h0000;
    dbg_wdata = 16'hA000;
    @(negedge clk);
    check_eq("t2_idle_gnt", 32'(dbg_gnt), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t2_we", 32'({dbg_gnt, mem_we}), 32'd3);
      check_eq("t2_addr", 32'(mem_addr), 32'(i));
      check_eq("t2_data", 32'(mem_data), 32'(16'hA000 + 16'(i)));
      step();
      if (i < 4) begin
        dbg_addr  = 16'(i + 1);
        dbg_wdata = 16'hA000 + 16'(i + 1);
      end else begin
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("t2_we_after", 32'(mem_we), 32'd0);
    check_eq("t2_addr_hold", 32'(mem_addr), 32'h0004);
    check_eq("t2_no_rvalid", 32'(dbg_rvalid), 32'd0);
    step();
    cpu_read(16'h0002, rd);
    check_eq("t2_readback", 32'(rd), 32'hA002);

    // 3: continuous contention, burst limit 8 each way
    do_reset();
    dbg_req  = 1'b1;
    dbg_addr = 16'h0020;
    cpu_req  = 1'b1;
    cpu_addr = 16'h0010;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (c == 0) exp_own = 2'b00;
      else exp_own = (((c - 1) / 8) % 2 == 0) ? 2'b01 : 2'b10;
      check_eq($sformatf("t3_own_c%0d", c), 32'({cpu_gnt, dbg_gnt}), 32'(exp_own));
      if (c == 9) begin
        check_eq("t3_dbg_rv_sw", 32'({dbg_rvalid, cpu_rvalid}), 32'b10);
        check_eq("t3_dbg_rdata", 32'(dbg_rdata), 32'h5555);
      end
      if (c == 10) begin
        check_eq("t3_cpu_rv", 32'({dbg_rvalid, cpu_rvalid}), 32'b01);
        check_eq("t3_cpu_rdata", 32'(cpu_rdata), 32'h1234);
      end
      step();
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    step();
    step();

    // 4: locked 20-word debug load with the CPU waiting throughout
    do_reset();
    cpu_req   = 1'b1;
    cpu_addr  = 16'h0010;
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_lock  = 1'b1;
    dbg_addr  = 16'h0040;
    dbg_wdata = 16'hB000;
    @(negedge clk);
    check_eq("t4_hold_idle", 32'(cpu_hold), 32'd1);
    step();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq($sformatf("t4_lock_%0d", i), 32'({dbg_gnt, cpu_gnt, cpu_hold, mem_we}),
               32'b1011);
      check_eq($sformatf("t4_addr_%0d", i), 32'(mem_addr), 32'(16'h0040 + 16'(i)));
      step();
      if (i < 19) begin
        dbg_addr  = 16'h0040 + 16'(i + 1);
        dbg_wdata = 16'hB000 + 16'(i + 1);
      end else begin
        dbg_req = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("t4_drop_cycle", 32'({cpu_gnt, cpu_hold}), 32'b01);
    step();
    @(negedge clk);
    check_eq("t4_cpu_granted", 32'({cpu_gnt, cpu_hold}), 32'b10);
    step();
    cpu_req  = 1'b0;
    dbg_lock = 1'b0;
    dbg_we   = 1'b0;
    step();

    // 5: reset asserted the cycle after a read is accepted
    do_reset();
    cpu_req  = 1'b1;
    cpu_addr = 16'h0010;
    step();
    @(negedge clk);
    check_eq("t5_accept", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("t5_rvalid_drop", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check_eq("t5_gnt_clear", 32'({cpu_gnt, dbg_gnt}), 32'd0);
    check_eq("t5_we_busy", 32'({mem_we, busy}), 32'd0);
    @(negedge clk);
    check_eq("t5_we_in_rst", 32'(mem_we), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_after_rel", 32'({busy, cpu_gnt, cpu_rvalid, mem_we}), 32'd0);
    step();

    // 6: two IDLE ties in sequence
    do_reset();
    cpu_req  = 1'b1;
    cpu_addr = 16'h0010;
    dbg_req  = 1'b1;
    dbg_addr = 16'h0020;
    @(negedge clk);
    check_eq("t6_tie1_idle", 32'({cpu_gnt, dbg_gnt}), 32'b00);
    step();
    @(negedge clk);
    check_eq("t6_tie1_win", 32'({cpu_gnt, dbg_gnt}), 32'b01);
    step();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    step();
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    @(negedge clk);
    check_eq("t6_tie2_idle", 32'({cpu_gnt, dbg_gnt}), 32'b00);
    step();
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("t6_tie2_win", 32'({cpu_gnt, dbg_gnt}), 32'b10);
`else
    check_eq("t6_tie2_win", 32'({cpu_gnt, dbg_gnt}), 32'b01);
`endif
    step();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
